preif_multi: RTL and testbench

Parametrised pre-IF next-PC generation stage for the LoongArch pipeline. It generalises the dual-issue pre-IF to `FETCH_W` instructions per fetch. It absorbs the PC-buffer function internally as a pending-redirect register, tracks outstanding instruction-SRAM requests, and marks stale responses for discard after a redirect. It sits between the CSR/ID redirect sources and the IF stage, and drives the SRAM-like instruction port.

---
 rtl/preif_pkg.sv | 24 ++
 rtl/preif_out_track.sv | 43 ++++
 rtl/preif_multi.sv | 141 ++++++++++++++
 tb/tb_preif_multi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/preif_pkg.sv
// Shared types and constants for the multi-lane pre-IF stage.
// State encoding, redirect kind, default reset PC and the lane-offset width helper.
package preif_pkg;

  typedef enum logic [1:0] {
    BOOT_WAIT = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2,
    FLUSH     = 2'd3
  } preif_state_t;

  // An exception-class pending redirect (excep or ertn) cannot be displaced by a branch.
  typedef enum logic {
    KIND_BRANCH = 1'b0,
    KIND_EXCEP  = 1'b1
  } redir_kind_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

  function automatic int lane_bits(input int fetch_w);
    return $clog2(fetch_w);
  endfunction

endpackage

// File: rtl/preif_out_track.sv
// Outstanding inst-SRAM request counter plus the stale-response cancel counter.
// Responses return in order, so the oldest cancel_cnt responses are the stale ones.
module preif_out_track #(
  parameter int MAX_OUT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_accept,
  input  logic i_data_ok,
  input  logic i_cancel,
  output logic o_full,
  output logic o_discard
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_cancel_cnt;

  assign o_full    = (r_out_cnt == CW'(MAX_OUT));
  assign o_discard = i_data_ok && (r_cancel_cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt    <= '0;
      r_cancel_cnt <= '0;
    end else begin
      r_out_cnt <= r_out_cnt + CW'(i_accept) - CW'(i_data_ok);
      // A same-cycle accept belongs to the new stream, so it is not counted as stale.
      if (i_cancel)
        r_cancel_cnt <= r_out_cnt - CW'(i_data_ok);
      else if (o_discard)
        r_cancel_cnt <= r_cancel_cnt - CW'(1);
    end
  end

`ifndef SYNTHESIS
  a_no_orphan_data_ok : assert property (@(posedge clk) disable iff (rst)
    !(i_data_ok && (r_out_cnt == '0)));
`endif

endmodule

// File: rtl/preif_multi.sv
// Pre-IF next-PC generation for FETCH_W-wide fetch groups, with an internal
// pending-redirect register and tracking of outstanding inst-SRAM requests.
module preif_multi
  import preif_pkg::*;
#(
  parameter int              FETCH_W  = 2,
  parameter int              PC_W     = 32,
  parameter int              MAX_OUT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    next_allowin_i,
  input  logic                    excep_flush_i,
  input  logic                    excep_en_i,
  input  logic [PC_W-1:0]         excep_pc_i,
  input  logic                    ertn_en_i,
  input  logic [PC_W-1:0]         ertn_pc_i,
  input  logic                    branch_flag_i,
  input  logic [PC_W-1:0]         branch_pc_i,
  output logic                    inst_sram_req_o,
  output logic [PC_W-1:0]         inst_sram_addr_o,
  input  logic                    inst_sram_addr_ok_i,
  input  logic                    inst_sram_data_ok_i,
  output logic                    now_to_next_valid_o,
  output logic [FETCH_W*PC_W-1:0] to_if_pc_o,
  output logic [FETCH_W-1:0]      to_if_lane_mask_o,
  output logic                    discard_o
);

  localparam int              LANE_W     = lane_bits(FETCH_W);
  localparam int              OFF_W      = (LANE_W == 0) ? 1 : LANE_W;
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(4 * FETCH_W - 1);
  localparam logic [PC_W-1:0] GROUP_STEP = PC_W'(4 * FETCH_W);

  preif_state_t r_state, w_state_nxt;
  logic [PC_W-1:0] r_seq_pc;
  logic [PC_W-1:0] r_pend_pc, w_pend_pc_nxt;
  logic            r_pend_v, w_pend_v_nxt;
  redir_kind_t     r_pend_kind, w_pend_kind_nxt;

  logic              w_redir_v;
  logic [PC_W-1:0]   w_redir_pc;
  redir_kind_t       w_redir_kind;
  logic [PC_W-1:0]   w_cand;
  logic [PC_W-1:0]   w_aligned;
  logic [OFF_W-1:0]  w_lane_off;
  logic              w_full;
  logic              w_req;
  logic              w_accept;

  assign w_redir_v    = excep_en_i || ertn_en_i || branch_flag_i;
  assign w_redir_pc   = excep_en_i ? excep_pc_i : (ertn_en_i ? ertn_pc_i : branch_pc_i);
  assign w_redir_kind = (excep_en_i || ertn_en_i) ? KIND_EXCEP : KIND_BRANCH;

  assign w_cand    = w_redir_v ? w_redir_pc : (r_pend_v ? r_pend_pc : r_seq_pc);
  assign w_aligned = w_cand & ALIGN_MASK;

  generate
    if (LANE_W == 0) begin : g_single_lane
      assign w_lane_off = '0;
    end else begin : g_multi_lane
      assign w_lane_off = w_cand[LANE_W+1:2];
    end
  endgenerate

  // data_ok only reaches discard_o; req depends on the registered count alone.
  assign w_req    = !excep_flush_i && next_allowin_i && !w_full && (r_state != BOOT_WAIT);
  assign w_accept = w_req && inst_sram_addr_ok_i;

  assign inst_sram_req_o     = w_req;
  assign inst_sram_addr_o    = w_aligned;
  assign now_to_next_valid_o = w_accept;

  always_comb begin
    to_if_pc_o        = '0;
    to_if_lane_mask_o = '0;
    if (w_accept) begin
      for (int i = 0; i < FETCH_W; i++) begin
        to_if_pc_o[i*PC_W +: PC_W] = w_aligned + PC_W'(4 * i);
        to_if_lane_mask_o[i]       = (OFF_W'(i) >= w_lane_off);
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_pend_v_nxt    = r_pend_v;
    w_pend_pc_nxt   = r_pend_pc;
    w_pend_kind_nxt = r_pend_kind;
    if (w_accept) begin
      w_pend_v_nxt = 1'b0;
    end else if (w_redir_v &&
                 !(r_pend_v && (r_pend_kind == KIND_EXCEP) && (w_redir_kind == KIND_BRANCH))) begin
      w_pend_v_nxt    = 1'b1;
      w_pend_pc_nxt   = w_redir_pc;
      w_pend_kind_nxt = w_redir_kind;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT_WAIT:       w_state_nxt = RUN;
      RUN, HOLD, FLUSH: w_state_nxt = w_pend_v_nxt ? HOLD : RUN;
      default:         w_state_nxt = RUN;
    endcase
    if (excep_flush_i)
      w_state_nxt = FLUSH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BOOT_WAIT;
      r_seq_pc    <= RESET_PC;
      r_pend_v    <= 1'b0;
      r_pend_pc   <= '0;
      r_pend_kind <= KIND_BRANCH;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_v    <= w_pend_v_nxt;
      r_pend_pc   <= w_pend_pc_nxt;
      r_pend_kind <= w_pend_kind_nxt;
      if (w_accept)
        r_seq_pc <= w_aligned + GROUP_STEP;
    end
  end

  preif_out_track #(
    .MAX_OUT (MAX_OUT)
  ) u_out_track (
    .clk       (clk),
    .rst       (rst),
    .i_accept  (w_accept),
    .i_data_ok (inst_sram_data_ok_i),
    .i_cancel  (w_redir_v || excep_flush_i),
    .o_full    (w_full),
    .o_discard (discard_o)
  );

endmodule

// File: tb/tb_preif_multi.sv
// Directed bench for preif_multi: a FETCH_W=2 instance for most scenarios and
// a FETCH_W=4 instance for the partial-group mask case.
module tb_preif_multi;

  localparam int PC_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        allowin, flush, exc_en, ertn_en, br_en, addr_ok, data_ok;
  logic [31:0] exc_pc, ertn_pc, br_pc;
  logic        req, valid, discard;
  logic [31:0] addr;
  logic [63:0] lane_pc;
  logic [1:0]  mask;

  logic        allowin4, br_en4, addr_ok4;
  logic [31:0] br_pc4;
  logic        req4, valid4, discard4;
  logic [31:0] addr4;
  logic [127:0] lane_pc4;
  logic [3:0]  mask4;

  int n_pass = 0;
  int n_total = 0;

  preif_multi #(.FETCH_W(2), .PC_W(PC_W), .MAX_OUT(2), .RESET_PC(32'h1c00_0000)) u_dut (
    .clk(clk), .rst(rst), .next_allowin_i(allowin), .excep_flush_i(flush),
    .excep_en_i(exc_en), .excep_pc_i(exc_pc), .ertn_en_i(ertn_en), .ertn_pc_i(ertn_pc),
    .branch_flag_i(br_en), .branch_pc_i(br_pc),
    .inst_sram_req_o(req), .inst_sram_addr_o(addr),
    .inst_sram_addr_ok_i(addr_ok), .inst_sram_data_ok_i(data_ok),
    .now_to_next_valid_o(valid), .to_if_pc_o(lane_pc), .to_if_lane_mask_o(mask),
    .discard_o(discard)
  );

  preif_multi #(.FETCH_W(4), .PC_W(PC_W), .MAX_OUT(2), .RESET_PC(32'h1c00_0000)) u_dut4 (
    .clk(clk), .rst(rst), .next_allowin_i(allowin4), .excep_flush_i(1'b0),
    .excep_en_i(1'b0), .excep_pc_i(32'h0), .ertn_en_i(1'b0), .ertn_pc_i(32'h0),
    .branch_flag_i(br_en4), .branch_pc_i(br_pc4),
    .inst_sram_req_o(req4), .inst_sram_addr_o(addr4),
    .inst_sram_addr_ok_i(addr_ok4), .inst_sram_data_ok_i(1'b0),
    .now_to_next_valid_o(valid4), .to_if_pc_o(lane_pc4), .to_if_lane_mask_o(mask4),
    .discard_o(discard4)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    flush = 0; exc_en = 0; ertn_en = 0; br_en = 0; data_ok = 0;
  endtask

  initial begin
    rst = 1; allowin = 1; addr_ok = 1; quiet();
    exc_pc = '0; ertn_pc = '0; br_pc = '0;
    allowin4 = 0; br_en4 = 0; br_pc4 = '0; addr_ok4 = 0;

    #2;
    check("rst_req", req, 0);
    check("rst_addr", addr, 32'h1c00_0000);
    check("rst_valid", valid, 0);
    check("rst_mask", mask, 0);
    check("rst_lanes", lane_pc, 0);
    check("rst_discard", discard, 0);
    next_cycle();
    rst = 0;

    settle(); check("boot_no_req", req, 0);
    next_cycle();

    settle();
    check("seq0_addr", addr, 32'h1c00_0000);
    check("seq0_valid", valid, 1);
    check("seq0_mask", mask, 2'b11);
    check("seq0_lane1", lane_pc[63:32], 32'h1c00_0004);
    next_cycle();

    settle();
    check("seq1_addr", addr, 32'h1c00_0008);
    check("seq1_valid", valid, 1);
    next_cycle();

    data_ok = 1;
    settle();
    check("full_req", req, 0);
    check("full_dok_no_req", req, 0);
    check("full_dok_discard", discard, 0);
    next_cycle();

    addr_ok = 0;
    settle();
    check("reenable_req", req, 1);
    check("reenable_addr", addr, 32'h1c00_0010);
    next_cycle();

    quiet(); br_en = 1; br_pc = 32'h1c00_0104;
    settle();
    check("br_addr", addr, 32'h1c00_0100);
    check("br_no_valid", valid, 0);
    next_cycle();

    quiet();
    for (int i = 0; i < 2; i++) begin
      settle();
      check("hold_addr", addr, 32'h1c00_0100);
      next_cycle();
    end

    addr_ok = 1;
    settle();
    check("hold_acc_valid", valid, 1);
    check("hold_acc_mask", mask, 2'b10);
    check("hold_acc_lane0", lane_pc[31:0], 32'h1c00_0100);
    check("hold_acc_lane1", lane_pc[63:32], 32'h1c00_0104);
    next_cycle();

    settle();
    check("after_br_addr", addr, 32'h1c00_0108);
    check("after_br_mask", mask, 2'b11);
    next_cycle();

    exc_en = 1; exc_pc = 32'h1c00_8000;
    settle();
    check("exc_full_req", req, 0);
    check("exc_addr", addr, 32'h1c00_8000);
    next_cycle();

    quiet(); data_ok = 1; addr_ok = 0;
    settle();
    check("stale0_discard", discard, 1);
    next_cycle();

    settle();
    check("stale1_discard", discard, 1);
    check("stale1_req", req, 1);
    check("stale1_addr", addr, 32'h1c00_8000);
    next_cycle();

    data_ok = 0; addr_ok = 1;
    settle();
    check("exc_acc_valid", valid, 1);
    check("exc_acc_mask", mask, 2'b11);
    next_cycle();

    data_ok = 1; addr_ok = 0;
    settle();
    check("kept_discard", discard, 0);
    next_cycle();

    quiet(); exc_en = 1; exc_pc = 32'h1c00_a000;
    settle(); check("pend_exc_addr", addr, 32'h1c00_a000);
    next_cycle();

    quiet(); br_en = 1; br_pc = 32'h1c00_b000;
    settle(); check("br_same_cycle_addr", addr, 32'h1c00_b000);
    next_cycle();

    quiet();
    settle(); check("pend_keeps_exc", addr, 32'h1c00_a000);
    next_cycle();

    exc_en = 1; exc_pc = 32'h1c00_c000;
    ertn_en = 1; ertn_pc = 32'h1c00_d000;
    br_en = 1; br_pc = 32'h1c00_e000;
    addr_ok = 1;
    settle();
    check("prio_addr", addr, 32'h1c00_c000);
    check("prio_valid", valid, 1);
    check("prio_lane0", lane_pc[31:0], 32'h1c00_c000);
    next_cycle();

    quiet(); data_ok = 1; addr_ok = 0;
    settle();
    check("prio_seq_addr", addr, 32'h1c00_c008);
    check("prio_no_discard", discard, 0);
    next_cycle();

    quiet(); flush = 1; addr_ok = 1;
    settle(); check("flush_req", req, 0);
    next_cycle();

    quiet(); exc_en = 1; exc_pc = 32'h1c00_f000; addr_ok = 0;
    settle();
    check("post_flush_req", req, 1);
    check("post_flush_addr", addr, 32'h1c00_f000);
    next_cycle();

    quiet(); allowin = 0;
    settle();
    check("no_allowin_req", req, 0);
    check("no_allowin_addr", addr, 32'h1c00_f000);
    next_cycle();

    allowin4 = 1; addr_ok4 = 1; br_en4 = 1; br_pc4 = 32'h1c00_000c;
    settle();
    check("w4_addr", addr4, 32'h1c00_0000);
    check("w4_valid", valid4, 1);
    check("w4_mask", mask4, 4'b1000);
    check("w4_lane3", lane_pc4[127:96], 32'h1c00_000c);
    next_cycle();

    br_en4 = 0;
    settle();
    check("w4_next_addr", addr4, 32'h1c00_0010);
    check("w4_next_mask", mask4, 4'b1111);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
